// File: rtl/mips_isa_pkg.sv
// Shared MIPS-style ISA definitions: operation enumeration, opcodes and funct codes.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    OpAdd  = 5'd0,
    OpSub  = 5'd1,
    OpAnd  = 5'd2,
    OpOr   = 5'd3,
    OpXor  = 5'd4,
    OpNor  = 5'd5,
    OpSlt  = 5'd6,
    OpSll  = 5'd7,
    OpSrl  = 5'd8,
    OpSra  = 5'd9,
    OpRor  = 5'd10,
    OpRol  = 5'd11,
    OpLw   = 5'd12,
    OpSw   = 5'd13,
    OpBeq  = 5'd14,
    OpBne  = 5'd15,
    OpAddi = 5'd16,
    OpSlti = 5'd17,
    OpAndi = 5'd18,
    OpOri  = 5'd19,
    OpXori = 5'd20,
    OpJ    = 5'd21
  } op_e;

  localparam logic [5:0] OpcRtype = 6'b000000;
  localparam logic [5:0] OpcLw    = 6'b100011;
  localparam logic [5:0] OpcSw    = 6'b101011;
  localparam logic [5:0] OpcBeq   = 6'b000100;
  localparam logic [5:0] OpcBne   = 6'b000101;
  localparam logic [5:0] OpcAddi  = 6'b001000;
  localparam logic [5:0] OpcSlti  = 6'b001010;
  localparam logic [5:0] OpcAndi  = 6'b001100;
  localparam logic [5:0] OpcOri   = 6'b001101;
  localparam logic [5:0] OpcXori  = 6'b001110;
  localparam logic [5:0] OpcJ     = 6'b000010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnXor = 6'b100110;
  localparam logic [5:0] FnNor = 6'b100111;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnSrl = 6'b000010;
  localparam logic [5:0] FnSra = 6'b000011;
  localparam logic [5:0] FnRor = 6'b000001;
  localparam logic [5:0] FnRol = 6'b000101;

  function automatic logic is_branch(input logic [4:0] op);
    return (op == OpBeq) || (op == OpBne);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packing of an operation and its fields into a 32-bit instruction word.
module instr_field_pack
  import mips_isa_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  input  logic [15:0] offset_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  // Select the format from the op and assemble the word; unknown ops flag illegal.
  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (op_i)
      OpAdd:   word_o = {OpcRtype, rs_i, rt_i, rd_i, shamt_i, FnAdd};
      OpSub:   word_o = {OpcRtype, rs_i, rt_i, rd_i, shamt_i, FnSub};
      OpAnd:   word_o = {OpcRtype, rs_i, rt_i, rd_i, shamt_i, FnAnd};
      OpOr:    word_o = {OpcRtype, rs_i, rt_i, rd_i, shamt_i, FnOr};
      OpXor:   word_o = {OpcRtype, rs_i, rt_i, rd_i, shamt_i, FnXor};
      OpNor:   word_o = {OpcRtype, rs_i, rt_i, rd_i, shamt_i, FnNor};
      OpSlt:   word_o = {OpcRtype, rs_i, rt_i, rd_i, shamt_i, FnSlt};
      OpSll:   word_o = {OpcRtype, rs_i, rt_i, rd_i, shamt_i, FnSll};
      OpSrl:   word_o = {OpcRtype, rs_i, rt_i, rd_i, shamt_i, FnSrl};
      OpSra:   word_o = {OpcRtype, rs_i, rt_i, rd_i, shamt_i, FnSra};
      OpRor:   word_o = {OpcRtype, rs_i, rt_i, rd_i, shamt_i, FnRor};
      OpRol:   word_o = {OpcRtype, rs_i, rt_i, rd_i, shamt_i, FnRol};
      OpLw:    word_o = {OpcLw,   rs_i, rt_i, imm_i};
      OpSw:    word_o = {OpcSw,   rs_i, rt_i, imm_i};
      OpBeq:   word_o = {OpcBeq,  rs_i, rt_i, offset_i};
      OpBne:   word_o = {OpcBne,  rs_i, rt_i, offset_i};
      OpAddi:  word_o = {OpcAddi, rs_i, rt_i, imm_i};
      OpSlti:  word_o = {OpcSlti, rs_i, rt_i, imm_i};
      OpAndi:  word_o = {OpcAndi, rs_i, rt_i, imm_i};
      OpOri:   word_o = {OpcOri,  rs_i, rt_i, imm_i};
      OpXori:  word_o = {OpcXori, rs_i, rt_i, imm_i};
      OpJ:     word_o = {OpcJ, target_i};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program-load encoder: accepts instruction requests and writes encoded words to
// consecutive instruction-memory addresses, one write per two cycles at most.
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [4:0]        i_op,
  input  logic [4:0]        i_rs,
  input  logic [4:0]        i_rt,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_shamt,
  input  logic [15:0]       i_imm,
  input  logic [ADDR_W-1:0] i_target,
  input  logic              i_last,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_done,
  output logic              o_err
);

  // Wide enough that target - (counter + 1) never wraps, and at least 17 bits.
  localparam int unsigned OffW = (ADDR_W + 2 > 17) ? ADDR_W + 2 : 17;

  typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              done_q;
  logic              err_q;
  logic              last_q;

  logic [OffW-1:0]   off_full;
  logic              off_oor;
  logic [31:0]       pack_word;
  logic              pack_illegal;
  logic              reject;

  // Branch offset relative to the slot after the one being written; range-check to 16 bits.
  always_comb begin
    off_full = OffW'(i_target) - (OffW'(cnt_q) + OffW'(1));
    off_oor  = is_branch(i_op) &&
               !((&off_full[OffW-1:15]) || !(|off_full[OffW-1:15]));
    reject   = pack_illegal || off_oor;
  end

  instr_field_pack u_pack (
    .op_i      (i_op),
    .rs_i      (i_rs),
    .rt_i      (i_rt),
    .rd_i      (i_rd),
    .shamt_i   (i_shamt),
    .imm_i     (i_imm),
    .target_i  (26'(i_target)),
    .offset_i  (off_full[15:0]),
    .word_o    (pack_word),
    .illegal_o (pack_illegal)
  );

  // Session FSM with registered write-port, done and error outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_start) begin
            cnt_q   <= i_base_addr;
            err_q   <= 1'b0;
            state_q <= StAccept;
          end
        end
        StAccept: begin
          if (i_valid) begin
            last_q  <= i_last;
            state_q <= StWrite;
            if (reject) begin
              err_q <= 1'b1;
            end else begin
              we_q    <= 1'b1;
              addr_q  <= cnt_q;
              wdata_q <= pack_word;
            end
          end
        end
        StWrite: begin
          we_q <= 1'b0;
          // Only a completed write advances the counter; wrapping past the top flags an error.
          if (we_q) begin
            cnt_q <= cnt_q + ADDR_W'(1);
            if (&cnt_q) err_q <= 1'b1;
          end
          if (last_q) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            state_q <= StAccept;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_ready      = (state_q == StAccept);
  assign o_imem_we    = we_q;
  assign o_imem_addr  = addr_q;
  assign o_imem_wdata = wdata_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized sessions
// compared against a table-driven encoding model and an expected-write queue.
module tb_instr_encoder;

  localparam int AW = 10;
  localparam int AMAX = (1 << AW) - 1;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [AW-1:0] i_base_addr;
  logic          i_valid;
  logic          o_ready;
  logic [4:0]    i_op, i_rs, i_rt, i_rd, i_shamt;
  logic [15:0]   i_imm;
  logic [AW-1:0] i_target;
  logic          i_last;
  logic          o_imem_we;
  logic [AW-1:0] o_imem_addr;
  logic [31:0]   o_imem_wdata;
  logic          o_done;
  logic          o_err;

  instr_encoder #(.ADDR_W(AW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_op         (i_op),
    .i_rs         (i_rs),
    .i_rt         (i_rt),
    .i_rd         (i_rd),
    .i_shamt      (i_shamt),
    .i_imm        (i_imm),
    .i_target     (i_target),
    .i_last       (i_last),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // Expected writes, {addr, data}, in order.
  bit [AW+31:0] exp_q[$];
  bit [31:0]    last_wdata = 32'h0;
  int           m_cnt = 0;
  bit           m_err = 1'b0;

  // Encoding tables indexed by operation number.
  int unsigned rfunct [12] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h26, 32'h27,
                               32'h2a, 32'h00, 32'h02, 32'h03, 32'h01, 32'h05};
  int unsigned iopc [9] = '{32'h23, 32'h2b, 32'h04, 32'h05, 32'h08,
                            32'h0a, 32'h0c, 32'h0d, 32'h0e};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Returns {legal, word}.
  function automatic bit [32:0] model_word(input int op, input int rs, input int rt,
                                           input int rd, input int sh, input int imm,
                                           input int tgt, input int cnt);
    int unsigned w;
    int off;
    int unsigned f;
    if (op <= 11) begin
      w = (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | rfunct[op];
    end else if (op <= 20) begin
      f = imm & 32'hFFFF;
      if (op == 14 || op == 15) begin
        off = tgt - (cnt + 1);
        if (off < -32768 || off > 32767) return 33'h0;
        f = off & 32'hFFFF;
      end
      w = (iopc[op-12] << 26) | (rs << 21) | (rt << 16) | f;
    end else if (op == 21) begin
      w = (32'h2 << 26) | tgt;
    end else begin
      return 33'h0;
    end
    return {1'b1, w};
  endfunction

  // Every cycle: each write must be the next expected one; otherwise wdata must hold.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_imem_we) begin
        check("we_expected", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
          check("we_addr", 64'(o_imem_addr), 64'(exp_q[0][AW+31:32]));
          check("we_data", 64'(o_imem_wdata), 64'(exp_q[0][31:0]));
          void'(exp_q.pop_front());
        end
        check("ready_during_we", 64'(o_ready), 64'd0);
        last_wdata = o_imem_wdata;
      end else begin
        check("wdata_hold", 64'(o_imem_wdata), 64'(last_wdata));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(o_ready), 64'd0);
    check({tag, "_we"}, 64'(o_imem_we), 64'd0);
    check({tag, "_addr"}, 64'(o_imem_addr), 64'd0);
    check({tag, "_wdata"}, 64'(o_imem_wdata), 64'd0);
    check({tag, "_done"}, 64'(o_done), 64'd0);
    check({tag, "_err"}, 64'(o_err), 64'd0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    exp_q.delete();
    last_wdata = 32'h0;
    m_cnt = 0;
    m_err = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_outputs("reset");
    i_rst = 1'b0;
  endtask

  task automatic start_session(input int base);
    i_start = 1'b1;
    i_base_addr = AW'(base);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    m_cnt = base;
    m_err = 1'b0;
    check("start_ready", 64'(o_ready), 64'd1);
    check("start_err_clear", 64'(o_err), 64'd0);
  endtask

  task automatic drive_req(input int op, input int rs, input int rt, input int rd,
                           input int sh, input int imm, input int tgt, input bit last);
    int n = 0;
    while (!o_ready && n < 20) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check("ready_timeout", 64'(o_ready), 64'd1);
    i_op = 5'(op); i_rs = 5'(rs); i_rt = 5'(rt); i_rd = 5'(rd); i_shamt = 5'(sh);
    i_imm = 16'(imm); i_target = AW'(tgt); i_last = last; i_valid = 1'b1;
  endtask

  // One full request: acceptance, the write cycle, and the session end if last.
  task automatic send(input int op, input int rs, input int rt, input int rd, input int sh,
                      input int imm, input int tgt, input bit last, input bit poke_start);
    bit [32:0] m;
    drive_req(op, rs, rt, rd, sh, imm, tgt, last);
    if (poke_start) begin
      i_start = 1'b1;
      i_base_addr = AW'($urandom_range(0, AMAX));
    end
    m = model_word(op, rs, rt, rd, sh, imm, tgt, m_cnt);
    if (m[32]) exp_q.push_back({AW'(m_cnt), m[31:0]});
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_start = 1'b0;
    @(posedge i_clk);
    #1;
    check("write_pending", 64'(exp_q.size()), 64'd0);
    if (m[32]) begin
      if (m_cnt == AMAX) m_err = 1'b1;
      m_cnt = (m_cnt + 1) & AMAX;
    end else begin
      m_err = 1'b1;
    end
    check("err", 64'(o_err), 64'(m_err));
    if (last) begin
      check("done_pulse", 64'(o_done), 64'd1);
      check("ready_in_done", 64'(o_ready), 64'd0);
      @(posedge i_clk);
      #1;
      check("done_low", 64'(o_done), 64'd0);
      check("ready_idle", 64'(o_ready), 64'd0);
    end else begin
      check("no_done", 64'(o_done), 64'd0);
      check("ready_next", 64'(o_ready), 64'd1);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_valid = 1'b0;
    i_op = '0; i_rs = '0; i_rt = '0; i_rd = '0; i_shamt = '0; i_imm = '0;
    i_target = '0; i_last = 1'b0;

    // Hand-computed words pin the model.
    check("pin_add", 64'(model_word(0, 1, 2, 3, 0, 0, 0, 16)), 64'({1'b1, 32'h00221820}));
    check("pin_lw", 64'(model_word(12, 29, 8, 0, 0, 4, 0, 16)), 64'({1'b1, 32'h8FA80004}));
    check("pin_beq", 64'(model_word(14, 1, 2, 0, 0, 0, 12, 16)), 64'({1'b1, 32'h1022FFFB}));
    check("pin_j", 64'(model_word(21, 0, 0, 0, 0, 0, 64, 0)), 64'({1'b1, 32'h08000040}));
    check("pin_addi", 64'(model_word(16, 0, 1, 0, 0, 5, 0, 0)), 64'({1'b1, 32'h20010005}));
    check("pin_illegal", 64'(model_word(31, 0, 0, 0, 0, 0, 0, 0)), 64'd0);

    @(posedge i_clk);
    #1;
    do_reset();

    // ADD at 0x010.
    start_session(16);
    send(0, 1, 2, 3, 0, 0, 0, 1'b1, 1'b0);

    // BEQ at 0x010 to 0x00C, LW, then J with last.
    start_session(16);
    send(14, 1, 2, 0, 0, 0, 12, 1'b0, 1'b0);
    send(12, 29, 8, 0, 0, 4, 0, 1'b0, 1'b1);
    send(21, 0, 0, 0, 0, 0, 64, 1'b1, 1'b0);

    // Undefined op leaves the counter; the next ADDI lands on the same address.
    start_session(32);
    send(31, 3, 3, 3, 3, 3, 3, 1'b0, 1'b0);
    send(16, 0, 1, 0, 0, 5, 0, 1'b1, 1'b0);

    // Write at the top address wraps the counter and flags an error.
    start_session(AMAX);
    send(16, 0, 1, 0, 0, 5, 0, 1'b0, 1'b0);
    check("wrap_cnt_model", 64'(m_cnt), 64'd0);
    send(16, 2, 3, 0, 0, 7, 0, 1'b0, 1'b0);

    // Reset right after acceptance aborts the pending write.
    drive_req(16, 1, 1, 0, 0, 9, 0, 1'b0);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_rst = 1'b1;
    exp_q.delete();
    last_wdata = 32'h0;
    m_cnt = 0;
    m_err = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge i_clk);
    #1;
    check_reset_outputs("abort_hold");
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("abort_no_we", 64'(o_imem_we), 64'd0);
    check("abort_idle", 64'(o_ready), 64'd0);

    // Randomized sessions.
    for (int s = 0; s < 40; s++) begin
      int base;
      int n;
      base = ($urandom_range(0, 3) == 0) ? (AMAX - 3 + $urandom_range(0, 3))
                                          : $urandom_range(0, AMAX);
      n = $urandom_range(1, 6);
      start_session(base);
      for (int k = 0; k < n; k++) begin
        int op;
        op = ($urandom_range(0, 9) == 0) ? $urandom_range(22, 31) : $urandom_range(0, 21);
        send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, AMAX),
             (k == n - 1), ($urandom_range(0, 4) == 0));
      end
    end

    repeat (3) @(posedge i_clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
